// File: rtl/brick_pkg.sv
// Shared types and widths for the brick field game core: FSM state encoding,
// coordinate/arithmetic widths and a zero-extension helper for overlap math.
package brick_pkg;

  localparam int COORD_W = 9;
  localparam int ARITH_W = 11;
  localparam int SCORE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE,
    ST_WIN,
    ST_LOSE
  } state_e;

  // Screen coordinates are widened so box edges never wrap.
  function automatic logic [ARITH_W-1:0] to_arith(input logic [COORD_W-1:0] v);
    return {{(ARITH_W-COORD_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/brick_hit_detect.sv
// Ball/brick box overlap for every grid cell plus a lowest-index priority
// encoder over the cells that are currently allowed to register a hit.
module brick_hit_detect
  import brick_pkg::*;
#(
  parameter int NUM_COLS   = 6,
  parameter int NUM_ROWS   = 2,
  parameter int ORIGIN_X   = 134,
  parameter int COL_PITCH  = 63,
  parameter int BRICK_W    = 60,
  parameter int BRICK_H    = 20,
  parameter int BALL_SZ    = 8,
  localparam int NUM_BRICKS = NUM_ROWS * NUM_COLS,
  localparam int IDX_W      = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
  input  logic [COORD_W-1:0]    ball_x_i,
  input  logic [COORD_W-1:0]    ball_y_i,
  input  logic [COORD_W-1:0]    field_y_i,
  input  logic [NUM_BRICKS-1:0] enable_i,
  output logic [NUM_BRICKS-1:0] overlap_o,
  output logic                  hit_any_o,
  output logic [IDX_W-1:0]      hit_idx_o
);

  logic [ARITH_W-1:0]    bx_lo, bx_hi, by_lo, by_hi;
  logic [NUM_BRICKS-1:0] cand;

  assign bx_lo = to_arith(ball_x_i);
  assign bx_hi = bx_lo + ARITH_W'(BALL_SZ);
  assign by_lo = to_arith(ball_y_i);
  assign by_hi = by_lo + ARITH_W'(BALL_SZ);

  for (genvar gi = 0; gi < NUM_BRICKS; gi++) begin : g_brick
    localparam int ROW = gi / NUM_COLS;
    localparam int COL = gi % NUM_COLS;
    logic [ARITH_W-1:0] x_lo, y_lo;

    assign x_lo = ARITH_W'(ORIGIN_X + COL * COL_PITCH);
    assign y_lo = to_arith(field_y_i) + ARITH_W'(ROW * BRICK_H);
    assign overlap_o[gi] = (bx_lo < x_lo + ARITH_W'(BRICK_W)) && (bx_hi > x_lo) &&
                           (by_lo < y_lo + ARITH_W'(BRICK_H)) && (by_hi > y_lo);
  end

  assign cand = overlap_o & enable_i;

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    hit_any_o = 1'b0;
    hit_idx_o = '0;
    for (int i = NUM_BRICKS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit_any_o = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/brick_field_ctrl.sv
// Brick field game core: existence bitmap, timed descent, hit scoring, lives
// and the IDLE/PLAY/PAUSE/WIN/LOSE state machine. Define BRICK_HP_EN for
// two-hit bricks with per-brick re-arm once the ball leaves the brick.
module brick_field_ctrl
  import brick_pkg::*;
#(
  parameter int NUM_COLS   = 6,
  parameter int NUM_ROWS   = 2,
  parameter int ORIGIN_X   = 134,
  parameter int COL_PITCH  = 63,
  parameter int BRICK_W    = 60,
  parameter int BRICK_H    = 20,
  parameter int DROP_PX    = 20,
  parameter int DROP_TICKS = 50000000,
  parameter int DEATH_Y    = 400,
  parameter int BALL_SZ    = 8,
  parameter int MAX_LIVES  = 3,
  localparam int NUM_BRICKS = NUM_ROWS * NUM_COLS,
  localparam int IDX_W      = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_ni,
  input  logic [COORD_W-1:0]    ball_x_i,
  input  logic [COORD_W-1:0]    ball_y_i,
  input  logic                  ball_lost_i,
  output logic [NUM_BRICKS-1:0] bricks_exist_o,
  output logic [COORD_W-1:0]    field_y_o,
  output logic                  hit_valid_o,
  output logic [IDX_W-1:0]      hit_idx_o,
  output logic [SCORE_W-1:0]    score_o,
  output logic [1:0]            lives_o,
  output logic                  playing_o,
  output logic                  game_over_o,
  output logic                  victory_o
);

  localparam int                 CNT_W      = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DROP_TICKS - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [ARITH_W-1:0] FIELD_MAX  = ARITH_W'((1 << COORD_W) - 1);

  state_e                state_q;
  logic [NUM_BRICKS-1:0] exist_q, exist_d, enable, ball_overlap, hit_onehot, kill;
  logic [COORD_W-1:0]    field_y_q, field_y_d;
  logic [ARITH_W-1:0]    field_sum;
  logic [CNT_W-1:0]      cnt_q;
  logic                  hit_any, hit_valid_q;
  logic [IDX_W-1:0]      hit_idx, hit_idx_q;
  logic [SCORE_W-1:0]    score_q;
  logic [1:0]            lives_q;
  logic                  playing_q, game_over_q, victory_q;
  logic [NUM_ROWS-1:0]   row_dead;
  logic                  death;

  brick_hit_detect #(
    .NUM_COLS  (NUM_COLS),
    .NUM_ROWS  (NUM_ROWS),
    .ORIGIN_X  (ORIGIN_X),
    .COL_PITCH (COL_PITCH),
    .BRICK_W   (BRICK_W),
    .BRICK_H   (BRICK_H),
    .BALL_SZ   (BALL_SZ)
  ) u_hit (
    .ball_x_i  (ball_x_i),
    .ball_y_i  (ball_y_i),
    .field_y_i (field_y_q),
    .enable_i  (enable),
    .overlap_o (ball_overlap),
    .hit_any_o (hit_any),
    .hit_idx_o (hit_idx)
  );

  assign hit_onehot = hit_any ? (NUM_BRICKS'(1) << hit_idx) : '0;
  assign exist_d    = exist_q & ~kill;

`ifdef BRICK_HP_EN
  logic [NUM_BRICKS-1:0][1:0] hp_q;
  logic [NUM_BRICKS-1:0]      armed_q, last_hp;

  for (genvar gi = 0; gi < NUM_BRICKS; gi++) begin : g_hp
    assign last_hp[gi] = (hp_q[gi] == 2'd1);
  end

  // A brick re-arms only on a cycle where the ball does not touch it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hp_q    <= {NUM_BRICKS{2'd2}};
      armed_q <= '1;
    end else if (state_q == ST_IDLE) begin
      hp_q    <= {NUM_BRICKS{2'd2}};
      armed_q <= '1;
    end else begin
      armed_q <= (armed_q | ~ball_overlap) & ~hit_onehot;
      for (int i = 0; i < NUM_BRICKS; i++) begin
        if (hit_onehot[i]) hp_q[i] <= hp_q[i] - 2'd1;
      end
    end
  end

  assign kill   = hit_onehot & last_hp;
  assign enable = exist_q & armed_q & {NUM_BRICKS{state_q == ST_PLAY}};
`else
  logic unused_overlap;
  assign unused_overlap = ^ball_overlap;
  assign kill   = hit_onehot;
  assign enable = exist_q & {NUM_BRICKS{state_q == ST_PLAY}};
`endif

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    logic [ARITH_W-1:0] bottom;
    assign bottom       = to_arith(field_y_q) + ARITH_W'((gi + 1) * BRICK_H);
    assign row_dead[gi] = (|exist_q[gi*NUM_COLS +: NUM_COLS]) && (bottom >= ARITH_W'(DEATH_Y));
  end
  assign death = |row_dead;

  assign field_sum = to_arith(field_y_q) + ARITH_W'(DROP_PX);
  assign field_y_d = (field_sum > FIELD_MAX) ? '1 : field_sum[COORD_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      exist_q     <= '1;
      field_y_q   <= '0;
      cnt_q       <= '0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      victory_q   <= 1'b0;
    end else begin
      hit_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          exist_q   <= '1;
          field_y_q <= '0;
          cnt_q     <= '0;
          score_q   <= '0;
          lives_q   <= LIVES_INIT;
          if (!start_ni) begin
            state_q   <= ST_PLAY;
            playing_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (hit_any) begin
            hit_valid_q <= 1'b1;
            hit_idx_q   <= hit_idx;
          end
          exist_q <= exist_d;
          if ((|kill) && (score_q != '1)) score_q <= score_q + SCORE_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            field_y_q <= field_y_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (ball_lost_i) lives_q <= lives_q - 2'd1;
          // Loss outranks a same-cycle clear, which outranks a plain pause.
          if (death || (ball_lost_i && (lives_q == 2'd1))) begin
            state_q     <= ST_LOSE;
            playing_q   <= 1'b0;
            game_over_q <= 1'b1;
          end else if (exist_d == '0) begin
            state_q   <= ST_WIN;
            playing_q <= 1'b0;
            victory_q <= 1'b1;
          end else if (ball_lost_i) begin
            state_q   <= ST_PAUSE;
            playing_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (!start_ni) begin
            state_q   <= ST_PLAY;
            playing_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bricks_exist_o = exist_q;
  assign field_y_o      = field_y_q;
  assign hit_valid_o    = hit_valid_q;
  assign hit_idx_o      = hit_idx_q;
  assign score_o        = score_q;
  assign lives_o        = lives_q;
  assign playing_o      = playing_q;
  assign game_over_o    = game_over_q;
  assign victory_o      = victory_q;

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Bench for brick_field_ctrl: a rule-level game model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_brick_field_ctrl;

  localparam int NC = 6, NR = 2, NB = 12;
  localparam int OX = 134, CP = 63, BW = 60, BH = 20;
  localparam int DP = 20, DT = 200, DY = 100, BS = 8, ML = 3;
`ifdef BRICK_HP_EN
  localparam int HITS = 2;
`else
  localparam int HITS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_n = 1'b1;
  logic        ball_lost = 1'b0;
  logic [8:0]  ball_x = 9'd0;
  logic [8:0]  ball_y = 9'd300;
  logic [11:0] exist_o;
  logic [8:0]  field_y_o;
  logic        hit_valid_o;
  logic [3:0]  hit_idx_o;
  logic [15:0] score_o;
  logic [1:0]  lives_o;
  logic        playing_o, game_over_o, victory_o;

  always #5 clk = ~clk;

  brick_field_ctrl #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .ORIGIN_X(OX), .COL_PITCH(CP),
    .BRICK_W(BW), .BRICK_H(BH), .DROP_PX(DP), .DROP_TICKS(DT),
    .DEATH_Y(DY), .BALL_SZ(BS), .MAX_LIVES(ML)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_ni(start_n),
    .ball_x_i(ball_x), .ball_y_i(ball_y), .ball_lost_i(ball_lost),
    .bricks_exist_o(exist_o), .field_y_o(field_y_o),
    .hit_valid_o(hit_valid_o), .hit_idx_o(hit_idx_o),
    .score_o(score_o), .lives_o(lives_o),
    .playing_o(playing_o), .game_over_o(game_over_o), .victory_o(victory_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  typedef enum int {M_IDLE, M_PLAY, M_PAUSE, M_WIN, M_LOSE} mst_t;
  mst_t        m_st;
  logic [11:0] m_exist;
  int          m_fy, m_score, m_lives, m_cnt, m_hidx;
  bit          m_hv;
  int          m_hp[NB];
  bit          m_armed[NB];

  function automatic bit overlaps(int i, int bx, int by, int fy);
    int x0 = OX + (i % NC) * CP;
    int y0 = fy + (i / NC) * BH;
    return (bx < x0 + BW) && (bx + BS > x0) && (by < y0 + BH) && (by + BS > y0);
  endfunction

  task automatic model_new_game();
    m_exist = '1; m_fy = 0; m_score = 0; m_lives = ML; m_cnt = 0;
    for (int i = 0; i < NB; i++) begin m_hp[i] = 2; m_armed[i] = 1; end
  endtask

  task automatic model_reset();
    model_new_game();
    m_st = M_IDLE; m_hv = 0; m_hidx = 0;
  endtask

  task automatic model_step();
    int  hit = -1;
    bit  dead = 0;
    bit  lose;
    m_hv = 0;
    if (m_st == M_PLAY) begin
      for (int r = 0; r < NR; r++)
        if ((|m_exist[r*NC +: NC]) && (m_fy + (r + 1) * BH >= DY)) dead = 1;
      for (int i = 0; i < NB; i++)
        if (hit < 0 && m_exist[i] && (HITS == 1 || m_armed[i]) &&
            overlaps(i, int'(ball_x), int'(ball_y), m_fy)) hit = i;
    end
    if (m_st != M_IDLE)
      for (int i = 0; i < NB; i++)
        if (!overlaps(i, int'(ball_x), int'(ball_y), m_fy)) m_armed[i] = 1;
    case (m_st)
      M_IDLE: begin
        model_new_game();
        if (!start_n) m_st = M_PLAY;
      end
      M_PLAY: begin
        if (hit >= 0) begin
          m_hv = 1; m_hidx = hit; m_armed[hit] = 0;
          m_hp[hit] = m_hp[hit] - 1;
          if (HITS == 1 || m_hp[hit] == 0) begin
            m_exist[hit] = 1'b0;
            if (m_score < 65535) m_score++;
          end
        end
        if (m_cnt == DT - 1) begin
          m_cnt = 0;
          m_fy = (m_fy + DP > 511) ? 511 : m_fy + DP;
        end else m_cnt++;
        lose = dead || (ball_lost && m_lives == 1);
        if (ball_lost) m_lives--;
        if (lose) m_st = M_LOSE;
        else if (m_exist == 0) m_st = M_WIN;
        else if (ball_lost) m_st = M_PAUSE;
      end
      M_PAUSE: if (!start_n) m_st = M_PLAY;
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("bitmap", 32'(exist_o), 32'(m_exist));
    chk("field_y", 32'(field_y_o), 32'(m_fy));
    chk("hit_valid", 32'(hit_valid_o), 32'(m_hv));
    chk("hit_idx", 32'(hit_idx_o), 32'(m_hidx));
    chk("score", 32'(score_o), 32'(m_score));
    chk("lives", 32'(lives_o), 32'(m_lives));
    chk("playing", 32'(playing_o), 32'(m_st == M_PLAY));
    chk("game_over", 32'(game_over_o), 32'(m_st == M_LOSE));
    chk("victory", 32'(victory_o), 32'(m_st == M_WIN));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_n = 1'b1; ball_lost = 1'b0; ball_x = 9'd0; ball_y = 9'd300;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic start_game();
    start_n = 1'b0;
    cyc(1);
    start_n = 1'b1;
  endtask

  task automatic ball_away();
    ball_x = 9'd0; ball_y = 9'd300;
  endtask

  int hv_cnt;

  initial begin
    // Reset state and start
    do_reset();
    chk("rst_bitmap", 32'(exist_o), 32'h0FFF);
    chk("rst_lives", 32'(lives_o), 32'd3);
    chk("rst_field_y", 32'(field_y_o), 32'd0);
    chk("rst_playing", 32'(playing_o), 32'd0);
    start_game();
    chk("start_playing", 32'(playing_o), 32'd1);
    $display("txn start: playing=%0d bitmap=%h lives=%0d", playing_o, exist_o, lives_o);

    // Single hit on brick 0
    ball_x = 9'd140; ball_y = 9'd5;
    cyc(1);
    chk("hit0_valid", 32'(hit_valid_o), 32'd1);
    chk("hit0_idx", 32'(hit_idx_o), 32'd0);
    chk("hit0_bitmap", 32'(exist_o), (HITS == 1) ? 32'h0FFE : 32'h0FFF);
    chk("hit0_score", 32'(score_o), (HITS == 1) ? 32'd1 : 32'd0);
    chk("model_score_pin", 32'(m_score), (HITS == 1) ? 32'd1 : 32'd0);
    $display("txn hit(140,5): valid=%0d idx=%0d bitmap=%h score=%0d", hit_valid_o, hit_idx_o, exist_o, score_o);
    ball_away();
    cyc(1);
    chk("hit0_pulse_end", 32'(hit_valid_o), 32'd0);

    // Two simultaneous overlaps: lowest index first
    do_reset(); start_game();
    ball_x = 9'd191; ball_y = 9'd5;
    cyc(1);
    chk("dual_first_idx", 32'(hit_idx_o), 32'd0);
    chk("dual_first_bitmap", 32'(exist_o), (HITS == 1) ? 32'h0FFE : 32'h0FFF);
    cyc(1);
    chk("dual_second_valid", 32'(hit_valid_o), 32'd1);
    chk("dual_second_idx", 32'(hit_idx_o), 32'd1);
    chk("dual_second_bitmap", 32'(exist_o), (HITS == 1) ? 32'h0FFC : 32'h0FFF);
    $display("txn hit(191,5): idx=%0d bitmap=%h score=%0d", hit_idx_o, exist_o, score_o);
    ball_away();
    cyc(2);

    // Clear every brick -> victory
    do_reset(); start_game();
    hv_cnt = 0;
    for (int h = 0; h < HITS; h++) begin
      for (int i = 0; i < NB; i++) begin
        ball_x = 9'(OX + (i % NC) * CP + 20);
        ball_y = 9'((i / NC) * BH + 5);
        cyc(1);
        if (hit_valid_o) hv_cnt++;
        $display("txn clear brick %0d pass %0d: valid=%0d idx=%0d score=%0d", i, h, hit_valid_o, hit_idx_o, score_o);
        ball_away();
        cyc(1);
      end
    end
    chk("clear_pulses", 32'(hv_cnt), 32'(NB * HITS));
    chk("clear_victory", 32'(victory_o), 32'd1);
    chk("clear_score", 32'(score_o), 32'd12);
    chk("clear_bitmap", 32'(exist_o), 32'd0);
    chk("clear_playing", 32'(playing_o), 32'd0);

    // Lives: pause, resume, last life -> LOSE; hit alongside ball_lost still lands
    do_reset(); start_game();
    ball_lost = 1'b1; cyc(1); ball_lost = 1'b0;
    chk("lost1_lives", 32'(lives_o), 32'd2);
    chk("lost1_playing", 32'(playing_o), 32'd0);
    chk("lost1_game_over", 32'(game_over_o), 32'd0);
    $display("txn ball_lost #1: lives=%0d playing=%0d", lives_o, playing_o);
    ball_x = 9'(OX + 2 * CP + 20); ball_y = 9'd5;
    cyc(1);
    chk("pause_no_hit", 32'(hit_valid_o), 32'd0);
    ball_away();
    start_game();
    chk("resume1_playing", 32'(playing_o), 32'd1);
    ball_x = 9'd140; ball_y = 9'd5; ball_lost = 1'b1;
    cyc(1);
    ball_lost = 1'b0; ball_away();
    chk("lost2_lives", 32'(lives_o), 32'd1);
    chk("lost2_hit_valid", 32'(hit_valid_o), 32'd1);
    chk("lost2_bitmap", 32'(exist_o), (HITS == 1) ? 32'h0FFE : 32'h0FFF);
    $display("txn ball_lost #2 with hit: lives=%0d valid=%0d bitmap=%h", lives_o, hit_valid_o, exist_o);
    start_game();
    ball_lost = 1'b1; cyc(1); ball_lost = 1'b0;
    chk("lost3_lives", 32'(lives_o), 32'd0);
    chk("lost3_game_over", 32'(game_over_o), 32'd1);
    chk("lost3_playing", 32'(playing_o), 32'd0);
    $display("txn ball_lost #3: lives=%0d game_over=%0d", lives_o, game_over_o);
    start_game();
    chk("lose_terminal", 32'(game_over_o), 32'd1);

    // Descent timing and death zone
    do_reset(); start_game();
    cyc(DT - 1);
    chk("drop_before", 32'(field_y_o), 32'd0);
    cyc(1);
    chk("drop1", 32'(field_y_o), 32'd20);
    $display("txn drop: field_y=%0d", field_y_o);
    cyc(DT);
    chk("drop2", 32'(field_y_o), 32'd40);
    $display("txn drop: field_y=%0d", field_y_o);
    cyc(DT);
    chk("drop3", 32'(field_y_o), 32'd60);
    chk("drop3_alive", 32'(game_over_o), 32'd0);
    $display("txn drop: field_y=%0d game_over=%0d", field_y_o, game_over_o);
    cyc(1);
    chk("death_game_over", 32'(game_over_o), 32'd1);
    chk("death_playing", 32'(playing_o), 32'd0);
    $display("txn death zone: game_over=%0d field_y=%0d", game_over_o, field_y_o);
    cyc(3);
    chk("death_field_hold", 32'(field_y_o), 32'd60);

    // Mid-game async reset
    start_n = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_game_over", 32'(game_over_o), 32'd0);
    chk("async_rst_field_y", 32'(field_y_o), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
